// File: rtl/lcd_multi_field_ctrl.sv
// Multi-field numeric LCD controller: converts NUM_FIELDS binary values to blanked decimal
// text and feeds lcd_show_char one character at a time, redrawing only fields that changed.
module lcd_multi_field_ctrl #(
  parameter int NUM_FIELDS = 4,
  parameter int VAL_W      = 8,
  parameter int DIGITS     = 3,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int CHAR_W     = 8,
  parameter int ROW_H      = 16,
  parameter bit EN_SIZE    = 1'b1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        init_done,
  input  logic                        show_char_done,
  input  logic [NUM_FIELDS*VAL_W-1:0] field_val,
  input  logic                        refresh,
  output logic                        en_size,
  output logic                        show_char_flag,
  output logic [6:0]                  ascii_num,
  output logic [8:0]                  start_x,
  output logic [8:0]                  start_y,
  output logic                        busy,
  output logic                        frame_done
);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BW = 4 * DIGITS;
  localparam int CW = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

  typedef enum logic [2:0] {IDLE, SCAN, CONV, CHAR, WAIT} state_t;

  state_t                      state_q, state_d;
  logic [NUM_FIELDS-1:0]       force_q, force_d;
  logic [NUM_FIELDS*VAL_W-1:0] shown_q, shown_d;
  logic [VAL_W-1:0]            cur_val_q, cur_val_d;
  logic [FW-1:0]               cur_field_q, cur_field_d;
  logic [FW-1:0]               last_field_q, last_field_d;
  logic                        drawn_q, drawn_d;
  logic                        ovf_q, ovf_d;
  logic [VAL_W-1:0]            bin_q, bin_d;
  logic [BW-1:0]               bcd_q, bcd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [2:0]                  digit_q, digit_d;
  logic                        flag_q, flag_d;
  logic [6:0]                  ascii_q, ascii_d;
  logic [8:0]                  x_q, x_d;
  logic [8:0]                  y_q, y_d;
  logic                        busy_q, busy_d;
  logic                        frame_q, frame_d;

  logic [NUM_FIELDS-1:0]       dirty;
  logic [BW-1:0]               bcd_adj;
  logic [BW-1:0]               bcd_step;
  logic                        found;
  int                          pick_idx;
  logic [VAL_W-1:0]            pick_val;

  // Leading zeros blank unless this is the units digit; overflow shows '#' everywhere.
  function automatic logic [6:0] char_of(input logic [BW-1:0] b, input logic [2:0] d,
                                         input logic ovf);
    logic [BW-1:0] upper;
    upper = b >> (4 * (DIGITS - 1 - int'(d)));
    if (ovf) return 7'h23;
    if ((int'(d) != DIGITS - 1) && (upper == '0)) return 7'h20;
    return 7'h30 + {3'b000, upper[3:0]};
  endfunction

  function automatic logic [8:0] pos_x(input logic [2:0] d);
    int v;
    v = X0 + int'(d) * CHAR_W;
    return v[8:0];
  endfunction

  function automatic logic [8:0] pos_y(input logic [FW-1:0] f);
    int v;
    v = Y0 + int'(f) * ROW_H;
    return v[8:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FIELDS; i++) begin
      dirty[i] = force_q[i] | (field_val[i*VAL_W +: VAL_W] != shown_q[i*VAL_W +: VAL_W]);
    end
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BW-2:0], bin_q[VAL_W-1]};
  end

  // Round-robin search begins one past the field drawn most recently.
  always_comb begin
    found    = 1'b0;
    pick_idx = 0;
    for (int k = 1; k <= NUM_FIELDS; k++) begin
      if (!found && dirty[(int'(last_field_q) + k) % NUM_FIELDS]) begin
        found    = 1'b1;
        pick_idx = (int'(last_field_q) + k) % NUM_FIELDS;
      end
    end
    pick_val = field_val[pick_idx*VAL_W +: VAL_W];
  end

  always_comb begin
    state_d      = state_q;
    force_d      = force_q;
    shown_d      = shown_q;
    cur_val_d    = cur_val_q;
    cur_field_d  = cur_field_q;
    last_field_d = last_field_q;
    drawn_d      = drawn_q;
    ovf_d        = ovf_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    flag_d       = 1'b0;
    ascii_d      = ascii_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_d      = 1'b0;
    case (state_q)
      IDLE: if (init_done) state_d = SCAN;
      SCAN: begin
        if (!init_done) begin
          force_d = '1;
          state_d = IDLE;
        end else if (found) begin
          cur_field_d       = FW'(pick_idx);
          cur_val_d         = pick_val;
          force_d[pick_idx] = 1'b0;
          ovf_d             = (32'(pick_val) >= LIMIT);
          bin_d             = pick_val;
          bcd_d             = '0;
          cnt_d             = '0;
          state_d           = CONV;
        end else if (drawn_q) begin
          frame_d = 1'b1;
          drawn_d = 1'b0;
        end
      end
      CONV: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(VAL_W - 1)) begin
          state_d = CHAR;
          digit_d = 3'd0;
          flag_d  = 1'b1;
          ascii_d = char_of(bcd_step, 3'd0, ovf_q);
          x_d     = pos_x(3'd0);
          y_d     = pos_y(cur_field_q);
        end
      end
      CHAR: state_d = WAIT;
      WAIT: begin
        if (show_char_done) begin
          if (digit_q == 3'(DIGITS - 1)) begin
            shown_d[int'(cur_field_q)*VAL_W +: VAL_W] = cur_val_q;
            last_field_d = cur_field_q;
            drawn_d      = 1'b1;
            state_d      = SCAN;
          end else begin
            digit_d = digit_q + 3'd1;
            state_d = CHAR;
            flag_d  = 1'b1;
            ascii_d = char_of(bcd_q, digit_q + 3'd1, ovf_q);
            x_d     = pos_x(digit_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (refresh) force_d = '1;
    busy_d = (state_d == CONV) || (state_d == CHAR) || (state_d == WAIT);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      force_q      <= '1;
      shown_q      <= '0;
      cur_val_q    <= '0;
      cur_field_q  <= '0;
      last_field_q <= FW'(NUM_FIELDS - 1);
      drawn_q      <= 1'b0;
      ovf_q        <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      digit_q      <= '0;
      flag_q       <= 1'b0;
      ascii_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      force_q      <= force_d;
      shown_q      <= shown_d;
      cur_val_q    <= cur_val_d;
      cur_field_q  <= cur_field_d;
      last_field_q <= last_field_d;
      drawn_q      <= drawn_d;
      ovf_q        <= ovf_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      flag_q       <= flag_d;
      ascii_q      <= ascii_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      frame_q      <= frame_d;
    end
  end

  assign en_size        = EN_SIZE;
  assign show_char_flag = flag_q;
  assign ascii_num      = ascii_q;
  assign start_x        = x_q;
  assign start_y        = y_q;
  assign busy           = busy_q;
  assign frame_done     = frame_q;

endmodule

// File: tb/tb_lcd_multi_field_ctrl.sv
// Directed bench for lcd_multi_field_ctrl: a 4-field/3-digit instance plus a 1-field/2-digit
// instance for the overflow display, each with a char-done responder 3 cycles after the flag.
module tb_lcd_multi_field_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        refresh = 1'b0;
  logic [31:0] field_val = 32'h0;
  logic        done1, done_auto1 = 1'b0, done_man = 1'b0, hold = 1'b0;
  logic        en1, flag1, busy1, frame1;
  logic [6:0]  ascii1;
  logic [8:0]  x1, y1;

  logic [7:0]  field_val2 = 8'd100;
  logic        done2 = 1'b0;
  logic        en2, flag2, busy2, frame2;
  logic [6:0]  ascii2;
  logic [8:0]  x2, y2;

  logic [24:0] q1[$];
  logic [24:0] q2[$];
  int          fd1 = 0;
  int          cnt1 = 0, cnt2 = 0;
  int          total = 0, bad = 0;
  logic        track = 1'b0, changed = 1'b0, notbusy = 1'b0;
  logic [24:0] snap = '0;

  always #5 clk = ~clk;
  assign done1 = done_auto1 | done_man;

  lcd_multi_field_ctrl dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .show_char_done(done1),
    .field_val(field_val), .refresh(refresh), .en_size(en1), .show_char_flag(flag1),
    .ascii_num(ascii1), .start_x(x1), .start_y(y1), .busy(busy1), .frame_done(frame1)
  );

  lcd_multi_field_ctrl #(.NUM_FIELDS(1), .DIGITS(2)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .show_char_done(done2),
    .field_val(field_val2), .refresh(1'b0), .en_size(en2), .show_char_flag(flag2),
    .ascii_num(ascii2), .start_x(x2), .start_y(y2), .busy(busy2), .frame_done(frame2)
  );

  // Responders and monitors, all acting on the falling edge.
  always @(negedge clk) begin
    done_auto1 = 1'b0;
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) done_auto1 = 1'b1;
    end
    if (flag1 && !hold) cnt1 = 3;
    done2 = 1'b0;
    if (cnt2 > 0) begin
      cnt2--;
      if (cnt2 == 0) done2 = 1'b1;
    end
    if (flag2) cnt2 = 3;
    if (flag1) q1.push_back({ascii1, x1, y1});
    if (flag2) q2.push_back({ascii2, x2, y2});
    if (frame1) fd1++;
    if (track) begin
      if ({ascii1, x1, y1} != snap) changed = 1'b1;
      if (!busy1) notbusy = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fv);
    @(negedge clk);
    field_val = fv;
  endtask

  task automatic waitChars(input int which, input int n);
    int b = 0;
    while (((which == 1) ? q1.size() : q2.size()) < n && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (((which == 1) ? q1.size() : q2.size()) < n)
      checkOutput("char_timeout", (which == 1) ? q1.size() : q2.size(), n);
  endtask

  task automatic checkField(input int which, input string tag, input int field, input string s);
    logic [24:0] got, exp;
    byte         ch;
    for (int d = 0; d < s.len(); d++) begin
      ch  = s[d];
      exp = {ch[6:0], 9'(8 * d), 9'(16 * field)};
      if (which == 1) got = (q1.size() > 0) ? q1.pop_front() : '1;
      else            got = (q2.size() > 0) ? q2.pop_front() : '1;
      checkOutput($sformatf("%s_d%0d", tag, d), 32'(got), 32'(exp));
    end
  endtask

  task automatic waitFrame(input string tag);
    int b = 0;
    while (fd1 == 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    repeat (10) @(posedge clk);
    checkOutput(tag, fd1, 1);
    checkOutput({tag, "_extra_chars"}, q1.size(), 0);
    fd1 = 0;
  endtask

  initial begin
    field_val = {8'd0, 8'd255, 8'd42, 8'd5};
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", {en1, flag1, ascii1, x1, y1, busy1, frame1}, {1'b1, 28'h0});
    rst_n = 1'b1;
    @(negedge clk);
    init_done = 1'b1;

    waitChars(1, 12);
    checkField(1, "t1_f0", 0, "  5");
    checkField(1, "t1_f1", 1, " 42");
    checkField(1, "t1_f2", 2, "255");
    checkField(1, "t1_f3", 3, "  0");
    waitFrame("t1_frame");

    applyStimulus({8'd0, 8'd7, 8'd42, 8'd5});
    waitChars(1, 3);
    checkField(1, "t2_f2", 2, "  7");
    waitFrame("t2_frame");

    waitChars(2, 2);
    checkField(2, "t3_ovf", 0, "##");
    @(negedge clk);
    field_val2 = 8'd9;
    waitChars(2, 2);
    checkField(2, "t3_nine", 0, " 9");

    hold = 1'b1;
    applyStimulus({8'd0, 8'd7, 8'd42, 8'd6});
    waitChars(1, 1);
    #1;
    snap = {ascii1, x1, y1};
    checkOutput("t4_first", 32'(snap), 32'({7'h20, 9'd0, 9'd0}));
    track = 1'b1;
    repeat (50) @(posedge clk);
    track = 1'b0;
    checkOutput("t4_flags", q1.size(), 1);
    checkOutput("t4_stable", changed, 0);
    checkOutput("t4_busy", notbusy, 0);
    @(negedge clk);
    hold = 1'b0;
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    waitChars(1, 3);
    checkField(1, "t4_f0", 0, "  6");
    waitFrame("t4_frame");

    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    waitChars(1, 12);
    checkField(1, "t5a_f1", 1, " 42");
    checkField(1, "t5a_f2", 2, "  7");
    checkField(1, "t5a_f3", 3, "  0");
    checkField(1, "t5a_f0", 0, "  6");
    waitFrame("t5a_frame");

    applyStimulus({8'd0, 8'd7, 8'd99, 8'd6});
    waitChars(1, 1);
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    waitChars(1, 15);
    checkField(1, "t5b_f1a", 1, " 99");
    checkField(1, "t5b_f2", 2, "  7");
    checkField(1, "t5b_f3", 3, "  0");
    checkField(1, "t5b_f0", 0, "  6");
    checkField(1, "t5b_f1b", 1, " 99");
    waitFrame("t5b_frame");

    hold = 1'b1;
    applyStimulus({8'd1, 8'd7, 8'd99, 8'd6});
    waitChars(1, 1);
    @(negedge clk);
    checkOutput("t6_in_wait", {busy1, flag1}, 2'b10);
    #2 rst_n = 1'b0;
    #1 checkOutput("t6_async", {en1, flag1, ascii1, x1, y1, busy1, frame1}, {1'b1, 28'h0});
    hold = 1'b0;
    q1.delete();
    q2.delete();
    fd1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitChars(1, 12);
    checkField(1, "t6_f0", 0, "  6");
    checkField(1, "t6_f1", 1, " 99");
    checkField(1, "t6_f2", 2, "  7");
    checkField(1, "t6_f3", 3, "  1");
    waitFrame("t6_frame");
    waitChars(2, 2);
    checkField(2, "t6_dut2", 0, " 9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
